// File: rtl/ev_shared_arbiter.sv
// rtl/ev_shared_arbiter.sv - round-robin arbiter for a shared word/dword store with lane locking
module ev_shared_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int NUM_WORDS = 16,
  parameter int LOCK_MAX  = 15
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_LANES-1:0]                         req,
  input  logic [NUM_LANES-1:0]                         we,
  input  logic [NUM_LANES-1:0]                         dw,
  input  logic [NUM_LANES-1:0]                         lock,
  input  logic [NUM_LANES-1:0][$clog2(NUM_WORDS)-1:0]  addr,
  input  logic [NUM_LANES-1:0][63:0]                   wdata,
  output logic [NUM_LANES-1:0]                         gnt,
  output logic [NUM_LANES-1:0]                         rvalid,
  output logic [63:0]                                  rdata,
  output logic                                         lock_err,
  output logic                                         locked
);

  localparam int AW = $clog2(NUM_WORDS);
  localparam int LW = $clog2(NUM_LANES);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(LOCK_MAX - 1);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [31:0]           r_mem [NUM_WORDS];
  logic [0:0]            r_state;
  logic [LW-1:0]         r_owner;
  logic [LW-1:0]         r_last;
  logic [CW-1:0]         r_cnt;
  logic [NUM_LANES-1:0]  r_rvalid;
  logic [63:0]           r_rdata;
  logic                  r_lock_err;

  logic                  w_found;
  logic [LW-1:0]         w_win;
  logic [LW-1:0]         w_cand;
  logic                  w_sel_we;
  logic                  w_sel_dw;
  logic                  w_sel_lock;
  logic [AW-1:0]         w_sel_addr;
  logic [63:0]           w_sel_wdata;
  logic [AW-1:0]         w_lo_addr;
  logic [AW-1:0]         w_hi_addr;
  logic                  w_expire;

  // While locked only the owner competes; otherwise scan from the lane after the last winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_cand  = r_last;
    if (r_state == ST_LOCKED) begin
      w_found = req[r_owner];
      w_win   = r_owner;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        w_cand = (w_cand == LAST_LANE) ? '0 : w_cand + 1'b1;
        if (!w_found && req[w_cand]) begin
          w_found = 1'b1;
          w_win   = w_cand;
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      gnt[i] = rst_n && w_found && (w_win == LW'(i));
    end
  end

  assign w_sel_we    = we[w_win];
  assign w_sel_dw    = dw[w_win];
  assign w_sel_lock  = lock[w_win];
  assign w_sel_addr  = addr[w_win];
  assign w_sel_wdata = wdata[w_win];
  assign w_lo_addr   = {w_sel_addr[AW-1:1], 1'b0};
  assign w_hi_addr   = {w_sel_addr[AW-1:1], 1'b1};
  assign w_expire    = (r_state == ST_LOCKED) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        r_mem[k] <= '0;
      end
    end else if (w_found && w_sel_we) begin
      if (w_sel_dw) begin
        r_mem[w_lo_addr] <= w_sel_wdata[31:0];
        r_mem[w_hi_addr] <= w_sel_wdata[63:32];
      end else begin
        r_mem[w_sel_addr] <= w_sel_wdata[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= gnt & ~we;
      if (w_found && !w_sel_we) begin
        r_rdata <= w_sel_dw ? {r_mem[w_hi_addr], r_mem[w_lo_addr]}
                            : {32'h0, r_mem[w_sel_addr]};
      end
    end
  end

  // Forced release leaves r_last alone so the former owner goes to the back of the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_cnt      <= '0;
      r_last     <= LAST_LANE;
      r_lock_err <= 1'b0;
    end else begin
      r_lock_err <= w_expire;
      if (w_found) begin
        r_last <= w_win;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_found && w_sel_lock) begin
            r_state <= ST_LOCKED;
            r_owner <= w_win;
            r_cnt   <= '0;
          end
        end
        default: begin
          if (w_expire || (w_found && !w_sel_lock)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign rvalid   = r_rvalid;
  assign rdata    = r_rdata;
  assign lock_err = r_lock_err;
  assign locked   = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_ev_shared_arbiter.sv
// tb/tb_ev_shared_arbiter.sv - directed and random checks of ev_shared_arbiter against a behavioural model
module tb_ev_shared_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int LM = 15;
  localparam int AW = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [N-1:0]             req, we, dw, lock;
  logic [N-1:0][AW-1:0]     addr;
  logic [N-1:0][63:0]       wdata;
  logic [N-1:0]             gnt, rvalid;
  logic [63:0]              rdata;
  logic                     lock_err, locked;

  always #5 clk = ~clk;

  ev_shared_arbiter #(.NUM_LANES(N), .NUM_WORDS(W), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .dw(dw), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .lock_err(lock_err), .locked(locked)
  );

  int n_checks = 0;
  int n_err = 0;

  logic [31:0] m_mem [W];
  logic [1:0]  m_last, m_owner, m_wl;
  int          m_win, m_age;
  bit          m_locked;
  logic [N-1:0] e_rvalid, seen_gnt;
  logic [63:0] e_rdata;
  logic        e_lock_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < W; k++) m_mem[k] = '0;
    m_last = 2'd3; m_owner = 2'd0; m_locked = 0; m_age = 0;
    e_rvalid = '0; e_rdata = '0; e_lock_err = 1'b0;
  endtask

  // Winner: the locked owner if it asks, else first requester after the last winner.
  task automatic model_pick();
    logic [1:0] l;
    m_win = -1;
    m_wl = 2'd0;
    if (m_locked) begin
      if (req[m_owner]) begin m_win = int'(m_owner); m_wl = m_owner; end
    end else begin
      for (int k = 1; k <= N; k++) begin
        l = 2'((int'(m_last) + k) % N);
        if (m_win < 0 && req[l]) begin m_win = int'(l); m_wl = l; end
      end
    end
  endtask

  task automatic model_edge();
    logic [3:0] a, lo, hi;
    e_rvalid = '0;
    e_lock_err = 1'b0;
    if (m_win >= 0) begin
      a = addr[m_wl]; lo = {a[3:1], 1'b0}; hi = {a[3:1], 1'b1};
      if (we[m_wl]) begin
        if (dw[m_wl]) begin
          m_mem[lo] = wdata[m_wl][31:0];
          m_mem[hi] = wdata[m_wl][63:32];
        end else begin
          m_mem[a] = wdata[m_wl][31:0];
        end
      end else begin
        e_rvalid[m_wl] = 1'b1;
        e_rdata = dw[m_wl] ? {m_mem[hi], m_mem[lo]} : {32'h0, m_mem[a]};
      end
      m_last = m_wl;
    end
    if (m_locked) begin
      m_age++;
      if (m_age >= LM) begin m_locked = 0; e_lock_err = 1'b1; end
      else if (m_win >= 0 && !lock[m_wl]) m_locked = 0;
    end else if (m_win >= 0 && lock[m_wl]) begin
      m_locked = 1; m_owner = m_wl; m_age = 0;
    end
  endtask

  task automatic do_cycle(input string tag);
    logic [N-1:0] exp_gnt;
    @(negedge clk);
    model_pick();
    exp_gnt = (m_win >= 0) ? (4'b0001 << m_wl) : 4'b0000;
    seen_gnt = gnt;
    chk({tag, "/gnt"}, 64'(gnt), 64'(exp_gnt));
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "/rvalid"}, 64'(rvalid), 64'(e_rvalid));
    chk({tag, "/rdata"}, rdata, e_rdata);
    chk({tag, "/lock_err"}, 64'(lock_err), 64'(e_lock_err));
    chk({tag, "/locked"}, 64'(locked), 64'(m_locked));
  endtask

  task automatic clear_inputs();
    req = '0; we = '0; dw = '0; lock = '0; addr = '0; wdata = '0;
  endtask

  task automatic set_lane(input logic [1:0] l, input logic w, input logic d, input logic lk,
                          input logic [3:0] a, input logic [63:0] wd);
    req[l] = 1'b1; we[l] = w; dw[l] = d; lock[l] = lk; addr[l] = a; wdata[l] = wd;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    req = 4'b1111;
    #12;
    chk("rst/gnt", 64'(gnt), 64'h0);
    chk("rst/rvalid", 64'(rvalid), 64'h0);
    chk("rst/rdata", rdata, 64'h0);
    chk("rst/lock_err", 64'(lock_err), 64'h0);
    chk("rst/locked", 64'(locked), 64'h0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle("idle");

    for (int i = 0; i < N; i++) set_lane(2'(i), 1'b0, 1'b0, 1'b0, 4'(i), 64'h0);
    for (int i = 0; i < N; i++) begin
      do_cycle("rr");
      chk("rr_seq", 64'(seen_gnt), 64'(4'b0001 << i));
      chk("rr_rvalid", 64'(rvalid), 64'(4'b0001 << i));
    end

    clear_inputs(); set_lane(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 64'd10); do_cycle("w0");
    set_lane(2'd0, 1'b1, 1'b0, 1'b0, 4'd1, 64'd14); do_cycle("w1");
    clear_inputs(); set_lane(2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 64'h0); do_cycle("dr0");
    chk("dword_rd", rdata, 64'h0000000E_0000000A);

    clear_inputs(); set_lane(2'd2, 1'b1, 1'b1, 1'b0, 4'd3, 64'd1780); do_cycle("dw3");
    clear_inputs(); set_lane(2'd2, 1'b0, 1'b0, 1'b0, 4'd2, 64'h0); do_cycle("rd2");
    chk("word2", rdata, 64'd1780);
    set_lane(2'd2, 1'b0, 1'b0, 1'b0, 4'd3, 64'h0); do_cycle("rd3");
    chk("word3", rdata, 64'd0);

    clear_inputs(); set_lane(2'd1, 1'b0, 1'b0, 1'b1, 4'd0, 64'h0); do_cycle("lk1");
    chk("lk1_locked", 64'(locked), 64'h1);
    clear_inputs();
    set_lane(2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
    set_lane(2'd3, 1'b0, 1'b0, 1'b0, 4'd5, 64'h0);
    for (int i = 0; i < 2; i++) begin
      do_cycle("stall");
      chk("lock_stall", 64'(seen_gnt), 64'h0);
    end
    set_lane(2'd1, 1'b1, 1'b0, 1'b0, 4'd5, 64'd65); do_cycle("rel1");
    chk("rel_gnt", 64'(seen_gnt), 64'b0010);
    chk("rel_unlock", 64'(locked), 64'h0);
    req[1] = 1'b0; do_cycle("after_rel");
    chk("after_rel_gnt", 64'(seen_gnt), 64'b1000);
    chk("word5", rdata, 64'd65);

    clear_inputs(); set_lane(2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 64'h0); do_cycle("lk0");
    clear_inputs(); set_lane(2'd2, 1'b0, 1'b0, 1'b0, 4'd2, 64'h0);
    for (int i = 1; i < LM; i++) do_cycle("hold");
    chk("hold_locked", 64'(locked), 64'h1);
    do_cycle("expire");
    chk("exp_lock_err", 64'(lock_err), 64'h1);
    chk("exp_locked", 64'(locked), 64'h0);
    do_cycle("post_exp");
    chk("post_exp_gnt", 64'(seen_gnt), 64'b0100);
    chk("post_exp_err", 64'(lock_err), 64'h0);

    clear_inputs(); set_lane(2'd1, 1'b0, 1'b0, 1'b1, 4'd0, 64'h0); do_cycle("lk1b");
    clear_inputs();
    for (int i = 1; i < LM; i++) do_cycle("hold_b");
    set_lane(2'd1, 1'b1, 1'b0, 1'b1, 4'd7, 64'd99); do_cycle("edge_wr");
    chk("edge_gnt", 64'(seen_gnt), 64'b0010);
    chk("edge_err", 64'(lock_err), 64'h1);
    chk("edge_locked", 64'(locked), 64'h0);
    clear_inputs(); set_lane(2'd1, 1'b0, 1'b0, 1'b0, 4'd7, 64'h0); do_cycle("rd7");
    chk("word7", rdata, 64'd99);

    clear_inputs(); set_lane(2'd3, 1'b0, 1'b0, 1'b1, 4'd5, 64'h0); do_cycle("lk3");
    set_lane(2'd3, 1'b0, 1'b0, 1'b1, 4'd7, 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst/gnt", 64'(gnt), 64'h0);
    chk("mid_rst/rvalid", 64'(rvalid), 64'h0);
    chk("mid_rst/locked", 64'(locked), 64'h0);
    chk("mid_rst/rdata", rdata, 64'h0);
    @(posedge clk);
    #1;
    chk("mid_rst/no_rvalid", 64'(rvalid), 64'h0);
    clear_inputs();
    set_lane(2'd1, 1'b0, 1'b0, 1'b0, 4'd5, 64'h0);
    set_lane(2'd2, 1'b0, 1'b1, 1'b0, 4'd6, 64'h0);
    rst_n = 1'b1;
    do_cycle("post_rst");
    chk("post_rst_gnt", 64'(seen_gnt), 64'b0010);
    chk("cleared5", rdata, 64'h0);
    do_cycle("post_rst2");
    chk("post_rst2_gnt", 64'(seen_gnt), 64'b0100);
    chk("cleared67", rdata, 64'h0);

    for (int i = 0; i < 400; i++) begin
      req   = 4'($urandom);
      we    = 4'($urandom);
      dw    = 4'($urandom);
      lock  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      for (int l = 0; l < N; l++) begin
        addr[l]  = 4'($urandom);
        wdata[l] = {$urandom, $urandom};
      end
      do_cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/ev_shared_arbiter.md
EV_SHARED_ARBITER -- requirements
Module: ev_shared_arbiter

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of requesting lanes (2..8).
REQ-002 SHALL have parameter NUM_WORDS, default 16, number of 32-bit shared words (even, power of 2).
REQ-003 SHALL have parameter LOCK_MAX, default 15, maximum cycles a lock may be held before forced release.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_LANES  per-lane access request, held until granted.
- we  in  NUM_LANES  per-lane write enable (1 = write, 0 = read).
- dw  in  NUM_LANES  per-lane dword access (1 = 64-bit, 0 = 32-bit word).
- lock  in  NUM_LANES  per-lane request to keep ownership after this access.
- addr  in  NUM_LANES x log2(NUM_WORDS)  per-lane word index.
- wdata  in  NUM_LANES x 64  per-lane write data (word access uses bits 31:0).
- gnt  out  NUM_LANES  one-hot grant, combinational, access performed on this edge.
- rvalid  out  NUM_LANES  registered read-data valid, one cycle after a granted read.
- rdata  out  64  registered read data.
- lock_err  out  1  one-cycle pulse on forced lock release.
- locked  out  1  high while the FSM is in LOCKED.

Function
REQ-005 SHALL hold NUM_WORDS x 32-bit shared storage; dword view: dword k = {word[2k+1], word[2k]}.
REQ-006 SHALL grant at most one lane per cycle; gnt[i] only when req[i]=1.
REQ-007 SHALL use round-robin priority: search starts at (last_winner+1) mod NUM_LANES; last_winner updates on every grant.
REQ-008 SHALL perform a granted word write as word[addr] <= wdata[31:0] on the grant edge.
REQ-009 SHALL perform a granted dword access with addr LSB forced to 0; a write updates word[addr&~1] <= wdata[31:0] and word[addr|1] <= wdata[63:32].
REQ-010 SHALL, on a granted read, register rdata on the grant edge and pulse rvalid[winner] for exactly one cycle after it; a word read drives rdata[63:32]=0.
REQ-011 SHALL hold rdata between reads; rvalid is 0 for every lane when there is no read grant.
REQ-012 SHALL implement FSM states IDLE and LOCKED.
REQ-013 IDLE: round-robin over all lanes; a grant with lock[w]=1 moves the FSM to LOCKED with owner=w and lock_cnt=0.
REQ-014 LOCKED: only owner may be granted; other requests stall with gnt=0.
REQ-015 LOCKED: an owner grant with lock=0 returns the FSM to IDLE after that access.
REQ-016 LOCKED: lock_cnt increments every cycle; when lock_cnt reaches LOCK_MAX with no releasing grant, the FSM returns to IDLE and pulses lock_err.
REQ-017 LOCKED: an owner grant in the same cycle as lock_cnt reaching LOCK_MAX is performed; release takes effect and lock_err still pulses.
REQ-018 The forced release SHALL NOT change last_winner, so the next IDLE search starts after the former owner.
REQ-019 A read and a write never coincide because a single grant exists per cycle; a read returns data written on an earlier edge.

Reset
REQ-020 While rst_n=0, all storage words SHALL be 0, gnt=0, rvalid=0, rdata=0, lock_err=0, locked=0, FSM=IDLE, lock_cnt=0, last_winner=NUM_LANES-1.
REQ-021 Reset assertion SHALL act immediately, including mid-LOCKED, and SHALL abort any pending rvalid; the first grant after release goes to the lowest-index requesting lane.

Verification
REQ-022 Reset; then req=4'b1111 with reads held for 4 cycles -> gnt sequence 0001, 0010, 0100, 1000, with rvalid following each grant by one cycle.
REQ-023 Lane 0 word writes addr=0 wdata=10, then addr=1 wdata=14; lane 1 dword read addr=0 -> rdata=64'h0000000E_0000000A.
REQ-024 Lane 2 dword write addr=3 wdata=64'd1780 -> word[2]=1780, word[3]=0; word read addr=2 -> rdata=1780.
REQ-025 Lane 1 read with lock=1; lanes 0 and 3 request continuously; lane 1 writes addr=5 wdata=65 with lock=0 after 3 cycles -> lanes 0 and 3 receive no grant while locked; next grant goes to lane 3; word[5]=65.
REQ-026 Set LOCK_MAX=15; lane 0 locks and then idles -> lock_err pulses once, locked falls 15 cycles after the lock grant, and waiting lane 2 is granted the next cycle.
REQ-027 Assert rst_n=0 mid-LOCKED with a read in flight -> no rvalid, storage cleared, locked=0; after release with req=4'b0110 -> first gnt=0010.
